alu_shift_seq: RTL and testbench
================================

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL expose these ports, with clock and reset first:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled on a rising clk edge.
- kill  input  1  synchronous abort of the operation in flight.
- A  input  32  shift amount; only A[4:0] is used, A[31:5] is ignored.
- B  input  32  operand to be shifted.
- op  input  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 ROTR (rotate right).
- Result  output  32  shift result, registered.
- busy  output  1  high while shifting.
- done  output  1  one-cycle completion pulse.

Function
REQ-003 The block SHALL implement three states: IDLE, SHIFT and DONE.
REQ-004 start SHALL be accepted only in IDLE or DONE; start while in SHIFT SHALL be ignored, with no effect on state, counter or Result.
REQ-005 On acceptance at edge E, the block SHALL load the working register (Result) with B, the counter with n = A[4:0], and latch op.
- Edge E SHALL count as the first cycle of latency.
REQ-006 After acceptance, the next state SHALL be DONE if n = 0, otherwise SHIFT.
REQ-007 In SHIFT, each rising edge SHALL shift Result by exactly one bit and decrement the counter by one:
- SLL: shift left, zero-fill bit 0.
- SRL: shift right, zero-fill bit 31.
- SRA: shift right, fill bit 31 with the latched B[31].
- ROTR: bit 0 goes to bit 31.
REQ-008 On the edge where the counter goes from 1 to 0, the next state SHALL be DONE.
REQ-009 done SHALL be high for exactly the one cycle following edge E+n, for every n in 0..31.
- Latency is n+1 edges, counting edge E.
REQ-010 busy SHALL equal 1 exactly while in SHIFT and 0 in IDLE and DONE.
REQ-011 From DONE, the block SHALL go to IDLE on the next edge unless a new start is accepted on that edge, which gives back-to-back operation with no bubble.
REQ-012 Result SHALL hold its final value from DONE until the next accepted start; during SHIFT it shows intermediate values.
REQ-013 op SHALL be latched at acceptance; changes to op, A or B during SHIFT SHALL have no effect.
REQ-014 kill high at an edge in SHIFT or DONE SHALL force IDLE, busy=0 and done=0 from the next cycle, with no done pulse for the aborted operation.
- Under kill, Result SHALL keep its current value.
REQ-015 kill SHALL take priority over start on the same edge; kill in IDLE SHALL have no effect.
REQ-016 The result SHALL equal the combinational equivalent for every op and n in 0..31: SLL B<<n, SRL B>>n, SRA arithmetic B>>n, ROTR rotate-right B by n.

Reset
REQ-017 Assertion of reset SHALL, without waiting for clk, force:
- state to IDLE;
- Result, the counter and the latched op to 0;
- busy=0 and done=0.
REQ-018 Reset asserted mid-operation SHALL discard that operation with no done pulse.
REQ-019 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- SLL, B=0x00000001, A=0x00000024 (n=4): busy high 4 cycles, done after edge E+4, Result=0x00000010.
- SRA, B=0x80000000, A=31: Result=0xFFFFFFFF after edge E+31. SRL with the same inputs: Result=0x00000001.
- SLL, B=0x12345678, A=0: no busy, done in the cycle after E, Result=0x12345678. ROTR, B=0x0000000F, A=4: Result=0xF0000000.
- Start with SRL, B=0xFFFFFFFF, A=8; pulse start (SLL, A=1) at E+3: second start is ignored, Result=0x00FFFFFF, single done. A new start in the DONE cycle is accepted back-to-back.
- kill at E+2 of a 10-bit shift: IDLE next cycle, no done. Reset at E+5 of a 20-bit shift: outputs 0 immediately, no done afterwards.
- Random: 10,000 operations with random start/kill gaps, checked against the REQ-016 model at each done.

Source files
------------

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: sequential shifter that moves Result one bit per clock for SLL/SRL/SRA/ROTR,
// with start/kill handshake and a one-cycle done pulse.
module alu_shift_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        kill,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  op,
   output logic [31:0] Result,
   output logic        busy,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      r_state, w_next;
   logic [4:0]  r_cnt;
   logic [1:0]  r_op;
   logic        r_sign;
   logic        w_accept;
   logic [31:0] w_step;
   logic        w_unused;
   assign w_unused = ^A[31:5];
   // kill outranks start in every state, so a killed edge never loads a new operation
   assign w_accept = start && !kill && r_state != SHIFT;
   assign busy = r_state == SHIFT;
   assign done = r_state == DONE;
   always_comb begin
      w_step = r_op == 2'b00 ? {Result[30:0], 1'b0}    :
               r_op == 2'b01 ? {1'b0, Result[31:1]}    :
               r_op == 2'b11 ? {r_sign, Result[31:1]}  :
                               {Result[0], Result[31:1]};
   end
   always_comb begin
      w_next = r_state;
      if (kill && r_state != IDLE)
         w_next = IDLE;
      else if (w_accept)
         w_next = A[4:0] == 5'd0 ? DONE : SHIFT;
      else if (r_state == SHIFT && r_cnt == 5'd1)
         w_next = DONE;
      else if (r_state == DONE)
         w_next = IDLE;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Result <= 32'd0;
         r_cnt  <= 5'd0;
         r_op   <= 2'd0;
         r_sign <= 1'b0;
      end else if (w_accept) begin
         Result <= B;
         r_cnt  <= A[4:0];
         r_op   <= op;
         r_sign <= B[31];
      end else if (r_state == SHIFT && !kill) begin
         Result <= w_step;
         r_cnt  <= r_cnt - 5'd1;
      end
   end
endmodule

// File: tb/tb_alu_shift_seq.sv
// tb_alu_shift_seq: directed table, hand-written corner sequences and random operations
// checked against an arithmetic reference of the shift functions.
module tb_alu_shift_seq;
   logic        clk = 1'b0;
   logic        reset, start, kill;
   logic [31:0] A, B;
   logic [1:0]  op;
   logic [31:0] Result;
   logic        busy, done;
   int          errors = 0;
   int          checks = 0;

   alu_shift_seq dut (
      .clk(clk), .reset(reset), .start(start), .kill(kill),
      .A(A), .B(B), .op(op), .Result(Result), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
   } vec_t;
   vec_t tbl[10];

   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] b, input int n);
      logic [63:0] d;
      d = {b, b} >> n;
      case (o)
         2'b00:   return b << n;
         2'b01:   return b >> n;
         2'b11:   return 32'($signed(b) >>> n);
         default: return d[31:0];
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      bcnt = 0;
      while (!done && lat < 40) begin
         bcnt += int'(busy);
         A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic wait_done(inout int lat);
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, bcnt, ndone, gap, rn, kat;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      bit killed;
      tbl[0] = '{2'b00, 32'h00000024, 32'h00000001, 32'h00000010};
      tbl[1] = '{2'b11, 32'd31,       32'h80000000, 32'hFFFFFFFF};
      tbl[2] = '{2'b01, 32'd31,       32'h80000000, 32'h00000001};
      tbl[3] = '{2'b00, 32'd0,        32'h12345678, 32'h12345678};
      tbl[4] = '{2'b10, 32'd4,        32'h0000000F, 32'hF0000000};
      tbl[5] = '{2'b10, 32'd8,        32'h12345678, 32'h78123456};
      tbl[6] = '{2'b11, 32'hFFFFFFE4, 32'h7FFFFFF0, 32'h07FFFFFF};
      tbl[7] = '{2'b01, 32'd8,        32'hFFFFFFFF, 32'h00FFFFFF};
      tbl[8] = '{2'b10, 32'd31,       32'h00000001, 32'h00000002};
      tbl[9] = '{2'b00, 32'd31,       32'hFFFFFFFF, 32'h80000000};
      reset = 1'b1; start = 1'b0; kill = 1'b0; A = '0; B = '0; op = '0;
      #1;
      chk("rst_result", Result, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt);
         chk($sformatf("tbl%0d_result", i), Result, tbl[i].res);
         chk($sformatf("tbl%0d_latency", i), lat, 32'(tbl[i].a[4:0]) + 1);
         chk($sformatf("tbl%0d_busy_cycles", i), bcnt, 32'(tbl[i].a[4:0]));
         @(negedge clk);
         chk($sformatf("tbl%0d_done_width", i), 32'(done), 32'd0);
      end

      // start during SHIFT is ignored, then back-to-back start from DONE
      @(negedge clk);
      start = 1'b1; op = 2'b01; A = 32'd8; B = 32'hFFFFFFFF;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk); start = 1'b1; op = 2'b00; A = 32'd1; B = 32'd0;
      @(negedge clk); start = 1'b0;
      lat = 4;
      wait_done(lat);
      chk("ign_latency", lat, 32'd9);
      chk("ign_result", Result, 32'h00FFFFFF);
      start = 1'b1; op = 2'b00; A = 32'd2; B = 32'd3;
      @(negedge clk); start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'd1);
      chk("b2b_done", 32'(done), 32'd0);
      lat = 1;
      wait_done(lat);
      chk("b2b_latency", lat, 32'd3);
      chk("b2b_result", Result, 32'h0000000C);

      // kill at E+2 of a 10-bit shift
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b00; A = 32'd10; B = 32'd1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); kill = 1'b1;
      @(negedge clk); kill = 1'b0;
      chk("kill_busy", 32'(busy), 32'd0);
      chk("kill_done", 32'(done), 32'd0);
      chk("kill_result", Result, 32'h00000002);
      ndone = 0;
      repeat (15) begin @(negedge clk); ndone += int'(done); end
      chk("kill_no_done", ndone, 32'd0);

      // kill beats a simultaneous start while in DONE
      run_op(2'b00, 32'd1, 32'h00000005, lat, bcnt);
      kill = 1'b1; start = 1'b1; A = 32'd0; B = 32'hDEADBEEF;
      @(negedge clk); kill = 1'b0; start = 1'b0;
      chk("kill_prio_done", 32'(done), 32'd0);
      chk("kill_prio_result", Result, 32'h0000000A);

      // asynchronous reset at E+5 of a 20-bit shift
      @(negedge clk);
      start = 1'b1; op = 2'b00; A = 32'd20; B = 32'd1;
      @(negedge clk); start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_result", Result, 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(done), 32'd0);
      @(negedge clk); reset = 1'b0;
      ndone = 0;
      repeat (25) begin @(negedge clk); ndone += int'(done); end
      chk("rst_no_done", ndone, 32'd0);
      run_op(2'b00, 32'd3, 32'd5, lat, bcnt);
      chk("post_rst_result", Result, 32'h00000028);
      chk("post_rst_latency", lat, 32'd4);

      // random operations with gaps, input noise, ignored starts and occasional kills
      @(negedge clk);
      for (int i = 0; i < 10000; i++) begin
         start = 1'b0; kill = 1'b0;
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         repeat (gap) @(negedge clk);
         rop = 2'($urandom_range(0, 3));
         ra = $urandom; rb = $urandom;
         rn = ($urandom_range(0, 4) == 0) ? int'(ra[4:0]) : int'(ra[1:0]);
         ra[4:0] = rn[4:0];
         kat = (rn > 0 && $urandom_range(0, 15) == 0) ? int'($urandom_range(1, rn)) : 0;
         start = 1'b1; op = rop; A = ra; B = rb;
         @(negedge clk);
         start = 1'b0;
         lat = 1;
         killed = 1'b0;
         while (!done && lat < 40) begin
            if (kat != 0 && lat == kat) begin
               kill = 1'b1;
               @(negedge clk);
               kill = 1'b0;
               chk("rnd_kill_state", {30'd0, busy, done}, 32'd0);
               chk("rnd_kill_result", Result, model(rop, rb, kat - 1));
               killed = 1'b1;
               break;
            end
            op = 2'($urandom_range(0, 3)); A = $urandom; B = $urandom;
            start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            start = 1'b0;
            lat++;
         end
         if (!killed) begin
            chk("rnd_result", Result, model(rop, rb, rn));
            chk("rnd_latency", lat, 32'(rn + 1));
         end
      end
      start = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
